col_parity_seq_ctrl: RTL

//  Control unit that sequences the 25-bit column-parity datapath over a block of NUM_PAGES pages.

---
 rtl/col_parity_pkg.sv | 17 +
 rtl/col_parity_seq_ctrl_if.sv | 27 ++
 rtl/col_parity_page_cnt.sv | 26 ++
 rtl/col_parity_seq_ctrl.sv | 122 ++++++++++++
 4 files changed

// File: rtl/col_parity_pkg.sv
// Shared types and constants for the column-parity sequencer.
// Pulled in by the controller and page counter via import col_parity_pkg::*.
package col_parity_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CALC,
        STORE,
        DONE,
        FIN
    } state_t;

    localparam int PAGE_W        = 25;
    localparam int DEF_NUM_PAGES = 64;

endpackage

// File: rtl/col_parity_seq_ctrl_if.sv
// Handshake and strobe bundle between host, controller and datapath.
// The stall signal exists only when COLPAR_STALL_EN is defined.
interface col_parity_seq_ctrl_if #(
    parameter int IDX_W = 6
);
    logic             start;
    logic             ready;
    logic             done;
    logic [IDX_W-1:0] page_index;
    logic             clr_dp;
    logic             ld_in;
    logic             calc_en;
    logic             ld_out;
`ifdef COLPAR_STALL_EN
    logic             stall;

    modport master (output start, stall,
                    input  ready, done, page_index, clr_dp, ld_in, calc_en, ld_out);
    modport slave  (input  start, stall,
                    output ready, done, page_index, clr_dp, ld_in, calc_en, ld_out);
`else
    modport master (output start,
                    input  ready, done, page_index, clr_dp, ld_in, calc_en, ld_out);
    modport slave  (input  start,
                    output ready, done, page_index, clr_dp, ld_in, calc_en, ld_out);
`endif
endinterface

// File: rtl/col_parity_page_cnt.sv
// Page address counter: synchronous clear, increment, and terminal flag
// asserted when the last page of a run is addressed.
module col_parity_page_cnt
    import col_parity_pkg::*;
#(
    parameter int NUM_PAGES = DEF_NUM_PAGES,
    parameter int IDX_W     = 6
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             inc,
    output logic [IDX_W-1:0] idx,
    output logic             last
);

    always_ff @(posedge clk) begin
        if (clr) begin
            idx <= '0;
        end else if (inc) begin
            idx <= idx + 1'b1;
        end
    end

    assign last = (idx == IDX_W'(NUM_PAGES - 1));

endmodule

// File: rtl/col_parity_seq_ctrl.sv
// Sequencer for the column-parity datapath: LOAD/CALC/STORE/DONE per page over a run.
// Optional COLPAR_STALL_EN adds a stall input that freezes the run in its active states.
module col_parity_seq_ctrl
    import col_parity_pkg::*;
#(
    parameter int NUM_PAGES   = DEF_NUM_PAGES,
    parameter int IDX_W       = 6,
    parameter int CALC_CYCLES = 1,
    parameter int CNT_W       = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    col_parity_seq_ctrl_if.slave bus
);

    localparam logic [CNT_W-1:0] CALC_LAST = CNT_W'(CALC_CYCLES - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             ready_q;
    logic             ld_in_q;
    logic             calc_q;
    logic             ld_out_q;
    logic             done_q;
    logic             hold;
    logic             last;
    logic             pg_clr;
    logic             pg_inc;
    logic [IDX_W-1:0] idx;

`ifdef COLPAR_STALL_EN
    assign hold = bus.stall && (state inside {LOAD, CALC, STORE, DONE});
`else
    assign hold = 1'b0;
`endif

    assign pg_clr = reset || (state == FIN && !bus.start);
    assign pg_inc = !reset && !hold && state == DONE && !last;

    col_parity_page_cnt #(
        .NUM_PAGES (NUM_PAGES),
        .IDX_W     (IDX_W)
    ) u_page_cnt (
        .clk  (clk),
        .clr  (pg_clr),
        .inc  (pg_inc),
        .idx  (idx),
        .last (last)
    );

    // Strobe registers are loaded with the value for the state being entered
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            ready_q  <= 1'b1;
            ld_in_q  <= 1'b0;
            calc_q   <= 1'b0;
            ld_out_q <= 1'b0;
            done_q   <= 1'b0;
        end else if (!hold) begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state   <= LOAD;
                        ready_q <= 1'b0;
                        ld_in_q <= 1'b1;
                    end
                end
                LOAD: begin
                    state   <= CALC;
                    cnt     <= '0;
                    ld_in_q <= 1'b0;
                    calc_q  <= 1'b1;
                end
                CALC: begin
                    if (cnt == CALC_LAST) begin
                        state    <= STORE;
                        calc_q   <= 1'b0;
                        ld_out_q <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STORE: begin
                    state    <= DONE;
                    ld_out_q <= 1'b0;
                    done_q   <= 1'b1;
                end
                DONE: begin
                    done_q <= 1'b0;
                    if (last) begin
                        state <= FIN;
                    end else begin
                        state   <= LOAD;
                        ld_in_q <= 1'b1;
                    end
                end
                FIN: begin
                    if (!bus.start) begin
                        state   <= IDLE;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    // clr_dp is the only strobe taken straight from start: it marks the IDLE->LOAD edge itself
    assign bus.ready      = ready_q || reset;
    assign bus.clr_dp     = ready_q && bus.start && !reset;
    assign bus.ld_in      = ld_in_q && !hold && !reset;
    assign bus.calc_en    = calc_q && !hold && !reset;
    assign bus.ld_out     = ld_out_q && !hold && !reset;
    assign bus.done       = done_q && !reset;
    assign bus.page_index = reset ? '0 : idx;

endmodule
